// File: rtl/fb_read_scheduler.sv
// Wishbone read master that walks a framebuffer linearly in incrementing bursts
// and pushes the returned RGB565 pixels into the display FIFO write port.
module fb_read_scheduler #(
    parameter int          HDISP      = 640,
    parameter int          VDISP      = 480,
    parameter int          BURST      = 16,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_wfree,
    output logic [15:0]                   fifo_wdata,
    output logic                          fifo_write,
    output logic [31:0]                   wb_adr,
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic                          wb_we,
    output logic [1:0]                    wb_sel,
    output logic [2:0]                    wb_cti,
    output logic [1:0]                    wb_bte,
    input  logic [15:0]                   wb_dat_sm,
    input  logic                          wb_ack,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int NPIX = HDISP * VDISP;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int BW   = $clog2(BURST + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pix_idx_q, pix_idx_d;
    logic [BW-1:0] beats_q, beats_d;
    logic          cyc_q, cyc_d;
    logic          write_q, write_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          done_q, done_d;

    logic [31:0]   remain;
    logic [31:0]   len;

    always_comb begin
        remain    = 32'(NPIX) - 32'(pix_idx_q);
        len       = (remain < 32'(BURST)) ? remain : 32'(BURST);

        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        beats_d   = beats_q;
        cyc_d     = cyc_q;
        write_d   = 1'b0;
        wdata_d   = wdata_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start && enable) begin
                    state_d   = S_WAIT;
                    pix_idx_d = '0;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    pix_idx_d = '0;
                end else if (32'(fifo_wfree) >= len) begin
                    state_d = S_BURST;
                    beats_d = BW'(len);
                    cyc_d   = 1'b1;
                end
            end
            S_BURST: begin
                if (wb_ack) begin
                    pix_idx_d = pix_idx_q + PW'(1);
                    beats_d   = beats_q - BW'(1);
                    write_d   = 1'b1;
                    wdata_d   = wb_dat_sm;
                    if (beats_q == BW'(1)) begin
                        cyc_d   = 1'b0;
                        state_d = S_GAP;
                    end
                end
            end
            default: begin
                // One idle cycle lets the last write land in fifo_wfree before the next room check
                if (32'(pix_idx_q) == 32'(NPIX)) begin
                    done_d    = 1'b1;
                    pix_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            pix_idx_q <= '0;
            beats_q   <= '0;
            cyc_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            beats_q   <= beats_d;
            cyc_q     <= cyc_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    assign wb_adr     = BASE_ADR + (32'(pix_idx_q) << 1);
    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = 1'b0;
    assign wb_sel     = 2'b11;
    assign wb_bte     = 2'b00;
    assign wb_cti     = cyc_q ? ((beats_q == BW'(1)) ? 3'b111 : 3'b010) : 3'b000;
    assign fifo_write = write_q;
    assign fifo_wdata = wdata_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Self-checking bench for fb_read_scheduler: random acks, data and FIFO room
// checked against a burst/pixel-level reference model of the frame walk.
module tb_fb_read_scheduler;

    localparam int HD   = 8;
    localparam int VD   = 2;
    localparam int BU   = 5;
    localparam int FD   = 256;
    localparam int NPIX = HD * VD;

    logic        CLK;
    logic        RST;
    logic        enable;
    logic        frame_start;
    logic [8:0]  fifo_wfree;
    logic [15:0] fifo_wdata;
    logic        fifo_write;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [15:0] wb_dat_sm;
    logic        wb_ack;
    logic        busy;
    logic        frame_done;

    fb_read_scheduler #(
        .HDISP(HD), .VDISP(VD), .BURST(BU), .FIFO_DEPTH(FD), .BASE_ADR(32'h0)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .frame_start(frame_start),
        .fifo_wfree(fifo_wfree), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
        .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_dat_sm(wb_dat_sm),
        .wb_ack(wb_ack), .busy(busy), .frame_done(frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          nchk, nerr, ncyc, done_at;
    int          exp_pix, burst_left, nwr, nbursts;
    int          ack_mode;
    bit          fs_noise, wfree_rand, done_seen;
    bit          pend_valid;
    logic [15:0] pend_data;
    logic        prev_cyc, prev_ack;
    logic [31:0] prev_adr;
    logic [2:0]  prev_cti;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pix    = 0;
        burst_left = 0;
        nwr        = 0;
        nbursts    = 0;
        done_at    = -1;
        pend_valid = 0;
        prev_cyc   = 0;
        prev_ack   = 0;
    endtask

    // One clock: observe the registered outputs #1 after the edge, then drive this cycle's inputs.
    task automatic step();
        logic [8:0] pw;
        logic       pe;
        logic       ack;
        int         len;
        pw = fifo_wfree;
        pe = enable;
        @(posedge CLK);
        #1;
        ncyc++;
        frame_start = 1'b0;

        chk("fifo_write", fifo_write, pend_valid);
        if (pend_valid) chk("fifo_wdata", fifo_wdata, pend_data);
        pend_valid = 0;
        chk("frame_done", frame_done, ncyc == done_at);
        done_seen |= frame_done;
        chk("wb_const", {wb_we, wb_sel, wb_bte}, 5'b0_11_00);

        if (wb_cyc && burst_left == 0 && !prev_cyc) begin
            len = (NPIX - exp_pix < BU) ? NPIX - exp_pix : BU;
            chk("start_adr", wb_adr, 32'(2 * exp_pix));
            chk("launch_ok", pe && (int'(pw) >= len), 1);
            burst_left = len;
            nbursts++;
        end else if (burst_left > 0) begin
            chk("cyc_hold", wb_cyc, 1);
        end else if (prev_cyc) begin
            chk("cyc_drop", wb_cyc, 0);
        end
        chk("stb", wb_stb, burst_left > 0);

        if (wb_cyc && prev_cyc && !prev_ack) begin
            chk("adr_stable", wb_adr, prev_adr);
            chk("cti_stable", wb_cti, prev_cti);
        end

        case (ack_mode)
            0:       ack = wb_cyc;
            1:       ack = wb_cyc && (ncyc % 3 == 0);
            default: ack = wb_cyc && ($urandom_range(0, 1) == 1);
        endcase
        if (burst_left == 0) ack = 1'b0;
        wb_dat_sm = 16'($urandom);
        if (ack) begin
            chk("beat_adr", wb_adr, 32'(2 * exp_pix));
            chk("beat_cti", wb_cti, (burst_left == 1) ? 3'b111 : 3'b010);
            pend_valid = 1;
            pend_data  = wb_dat_sm;
            exp_pix++;
            burst_left--;
            nwr++;
            if (exp_pix == NPIX) done_at = ncyc + 2;
        end
        wb_ack   = ack;
        prev_cyc = wb_cyc;
        prev_ack = ack;
        prev_adr = wb_adr;
        prev_cti = wb_cti;
        if (wfree_rand) fifo_wfree = 9'($urandom_range(0, 8));
        if (fs_noise && burst_left > 0) frame_start = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_done(input int budget, input bit fs_gap);
        int n;
        n = 0;
        done_seen = 0;
        while (!done_seen && n < budget) begin
            step();
            n++;
            if (fs_gap && ncyc == done_at - 1) frame_start = 1'b1;
        end
        chk("frame_timeout", done_seen, 1);
        chk("frame_writes", nwr, NPIX);
        chk("frame_bursts", nbursts, (NPIX + BU - 1) / BU);
    endtask

    task automatic run_frame(input bit fs_gap);
        model_reset();
        enable      = 1'b1;
        frame_start = 1'b1;
        wait_done(2000, fs_gap);
    endtask

    task automatic wait_pix(input int target);
        int n;
        n = 0;
        while (exp_pix < target && n < 200) begin
            step();
            n++;
        end
        chk("pix_timeout", exp_pix, target);
    endtask

    initial begin
        nchk = 0; nerr = 0; ncyc = 0;
        ack_mode = 0; fs_noise = 0; wfree_rand = 0;
        model_reset();
        RST = 1'b0; enable = 1'b0; frame_start = 1'b0; fifo_wfree = 9'd256;
        wb_ack = 1'b0; wb_dat_sm = '0;

        // Reset with random inputs toggling
        repeat (5) begin
            #3;
            enable = 1'($urandom); frame_start = 1'($urandom); wb_ack = 1'($urandom);
            wb_dat_sm = 16'($urandom); fifo_wfree = 9'($urandom);
            #4;
            chk("rst_ctl", {wb_cyc, wb_stb, wb_we, fifo_write, frame_done, busy, wb_cti, wb_bte}, 0);
            chk("rst_adr", wb_adr, 0);
            chk("rst_wdata", fifo_wdata, 0);
            chk("rst_sel", wb_sel, 2'b11);
        end
        enable = 1'b0; frame_start = 1'b0; wb_ack = 1'b0; fifo_wfree = 9'd256;
        @(negedge CLK);
        RST = 1'b1;
        repeat (10) begin
            step();
            chk("idle_cyc", wb_cyc, 0);
            chk("idle_busy", busy, 0);
        end

        // Nominal frame, ack every cycle; frame_start during the GAP cycle must be ignored
        run_frame(1);
        repeat (5) begin
            step();
            chk("post_done_busy", busy, 0);
        end

        // Wait states: ack every third cycle
        ack_mode = 1;
        run_frame(0);

        // Random acks with frame_start noise mid-burst
        ack_mode = 2; fs_noise = 1;
        repeat (3) run_frame(0);
        fs_noise = 0;

        // Random FIFO room
        wfree_rand = 1;
        repeat (2) run_frame(0);
        wfree_rand = 0;

        // Back-pressure: 4 free slots never admit a 5-beat burst
        ack_mode = 0;
        fifo_wfree = 9'd4;
        model_reset();
        enable = 1'b1; frame_start = 1'b1;
        step();
        repeat (10) begin
            step();
            chk("bp_cyc", wb_cyc, 0);
            chk("bp_busy", busy, 1);
        end
        fifo_wfree = 9'd5;
        step();
        chk("bp_launch", wb_cyc, 1);
        wait_done(2000, 0);
        fifo_wfree = 9'd256;

        // Abort: enable drops during beat 2, burst still finishes
        model_reset();
        enable = 1'b1; frame_start = 1'b1;
        wait_pix(2);
        enable = 1'b0;
        repeat (12) step();
        chk("abort_beats", exp_pix, BU);
        chk("abort_busy", busy, 0);
        run_frame(0);

        // Asynchronous reset during beat 3
        model_reset();
        enable = 1'b1; frame_start = 1'b1;
        wait_pix(3);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_cyc", wb_cyc, 0);
        chk("arst_stb", wb_stb, 0);
        chk("arst_write", fifo_write, 0);
        chk("arst_busy", busy, 0);
        @(posedge CLK);
        #1;
        chk("arst_ack_write", fifo_write, 0);
        chk("arst_ack_cyc", wb_cyc, 0);
        wb_ack = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        step();
        run_frame(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
